// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encoding and
// default configuration values.
package mux_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        OUTPUT = 2'd3
    } scan_state_t;

    localparam int unsigned DEF_SEL_W      = 4;
    localparam int unsigned DEF_SETTLE_CYC = 2;
    localparam int unsigned CNT_W          = 4;

    // Cycles from an accepted start to word_valid for n enabled channels.
    function automatic int unsigned scan_latency(input int unsigned n_en,
                                                 input int unsigned settle);
        return 1 + n_en * (settle + 1);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan word hand-off bus: the sequencer is master, the consumer is slave.
interface mux_scan_ctrl_if #(
    parameter int unsigned N_CH = 16
);
    logic [N_CH-1:0] scan_word;
    logic            word_valid;
    logic            word_ready;

    modport master (output scan_word, output word_valid, input word_ready);
    modport slave  (input scan_word, input word_valid, output word_ready);
endinterface

// File: rtl/mux_scan_ctrl_next_chan_find.sv
// Combinational search for the next enabled channel in a mask: the lowest
// enabled index strictly above cur, or the lowest enabled index when first=1.
module next_chan_find #(
    parameter int unsigned SEL_W = 4
) (
    input  logic [2**SEL_W-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    input  logic                first,
    output logic [SEL_W-1:0]    nxt,
    output logic                found
);

    // Ascending scan; the first qualifying hit wins.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 2**SEL_W; i++) begin
            if (!found && mask[i] && (first || i > 32'(cur))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer for the 16:1 mux: steps the select over enabled channels, waits a
// settle interval on each, samples mux_y into scan_word and hands the word off
// on a valid/ready handshake.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SEL_W      = DEF_SEL_W,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cont,
    input  logic                abort,
    input  logic [2**SEL_W-1:0] chan_mask,
    input  logic                mux_y,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    mux_scan_ctrl_if.master     word_if
);

    localparam int unsigned N_CH = 2**SEL_W;

    if (SETTLE_CYC == 0 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("mux_scan_ctrl: SETTLE_CYC must be in 1..15");
    end

    scan_state_t        state;
    logic [CNT_W-1:0]   settle_cnt;
    logic [N_CH-1:0]    mask_q;

    logic               find_first;
    logic [N_CH-1:0]    find_mask;
    logic [SEL_W-1:0]   find_idx;
    logic               find_ok;

    // Scan start (IDLE, or OUTPUT with cont) searches the live mask from the
    // bottom; mid-scan steps search the latched mask above the current sel.
    always_comb begin
        find_first = (state == IDLE) || (state == OUTPUT);
        find_mask  = find_first ? chan_mask : mask_q;
    end

    next_chan_find #(.SEL_W(SEL_W)) u_find (
        .mask  (find_mask),
        .cur   (sel),
        .first (find_first),
        .nxt   (find_idx),
        .found (find_ok)
    );

    // Scan FSM with registered sel, busy, scan_word and word_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            settle_cnt         <= '0;
            mask_q             <= '0;
            sel                <= '0;
            busy               <= 1'b0;
            word_if.scan_word  <= '0;
            word_if.word_valid <= 1'b0;
        end else if (abort) begin
            state              <= IDLE;
            settle_cnt         <= '0;
            sel                <= '0;
            busy               <= 1'b0;
            word_if.word_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q             <= chan_mask;
                        word_if.scan_word  <= '0;
                        settle_cnt         <= '0;
                        busy               <= 1'b1;
                        if (find_ok) begin
                            state <= SETTLE;
                            sel   <= find_idx;
                        end else begin
                            state              <= OUTPUT;
                            word_if.word_valid <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    word_if.scan_word[sel] <= mux_y;
                    if (find_ok) begin
                        state <= SETTLE;
                        sel   <= find_idx;
                    end else begin
                        state              <= OUTPUT;
                        word_if.word_valid <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (word_if.word_ready) begin
                        if (cont) begin
                            // Behaves as a start accepted this cycle; an empty
                            // mask re-presents an all-zero word immediately.
                            mask_q             <= chan_mask;
                            word_if.scan_word  <= '0;
                            settle_cnt         <= '0;
                            word_if.word_valid <= !find_ok;
                            if (find_ok) begin
                                state <= SETTLE;
                                sel   <= find_idx;
                            end
                        end else begin
                            state              <= IDLE;
                            busy               <= 1'b0;
                            word_if.word_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed scans push expected words
// (with the cycle word_valid must rise) into a scoreboard; a monitor pops and
// compares on every handshake.
module tb_mux_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic        abort;
    logic [15:0] chan_mask;
    logic        mux_y;
    logic [3:0]  sel;
    logic        busy;
    logic [15:0] di;

    mux_scan_ctrl_if #(.N_CH(16)) wif ();

    mux_scan_ctrl #(.SEL_W(4), .SETTLE_CYC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .abort     (abort),
        .chan_mask (chan_mask),
        .mux_y     (mux_y),
        .sel       (sel),
        .busy      (busy),
        .word_if   (wif)
    );

    // Behavioural stand-in for the 16:1 mux datapath.
    assign mux_y = di[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] word;
        int          rise;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: track the rise of word_valid, compare on every handshake.
    int   rise_cyc = -1;
    logic prev_v   = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (wif.word_valid && !prev_v) rise_cyc = cyc;
            prev_v = wif.word_valid;
            if (wif.word_valid && wif.word_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {16'h0, wif.scan_word}, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_word", {16'h0, wif.scan_word}, {16'h0, e.word});
                    chk("sb_latency", rise_cyc, e.rise);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) step();
    endtask

    task automatic issue(input logic [15:0] m, output int t0);
        chan_mask = m;
        start     = 1'b1;
        t0        = cyc;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            step();
            k++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int cnt;

        rst_n          = 1'b0;
        start          = 1'b0;
        cont           = 1'b0;
        abort          = 1'b0;
        chan_mask      = '0;
        di             = '0;
        wif.word_ready = 1'b1;

        // Reset values
        step();
        step();
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", wif.word_valid, 0);
        chk("rst_word", wif.scan_word, 0);
        rst_n = 1'b1;
        step();

        // 1: full mask, sel walks 0..15
        di = 16'hA5C3;
        issue(16'hFFFF, t0);
        sb.push_back('{word: 16'hA5C3, rise: t0 + 49});
        for (int i = 0; i < 16; i++) begin
            to_cycle(t0 + 1 + 3 * i);
            chk("t1_sel", sel, i);
        end
        wait_idle("t1_idle", 100);

        // 2: sparse mask visits only channels 0 and 15
        di = 16'hFFFF;
        issue(16'h8001, t0);
        sb.push_back('{word: 16'h8001, rise: t0 + 7});
        chk("t2_sel0", sel, 0);
        to_cycle(t0 + 4);
        chk("t2_sel15", sel, 15);
        wait_idle("t2_idle", 50);

        // 3: empty mask, word held while the consumer stalls
        wif.word_ready = 1'b0;
        issue(16'h0000, t0);
        sb.push_back('{word: 16'h0000, rise: t0 + 1});
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", wif.word_valid, 1);
            chk("t3_hold_word", wif.scan_word, 0);
            step();
        end
        wif.word_ready = 1'b1;
        step();
        chk("t3_valid_drop", wif.word_valid, 0);
        chk("t3_idle", busy, 0);

        // 4: cont gives back-to-back words with no IDLE gap
        cont = 1'b1;
        di   = 16'h0001;
        issue(16'h0003, t0);
        sb.push_back('{word: 16'h0001, rise: t0 + 7});
        sb.push_back('{word: 16'h0002, rise: t0 + 14});
        to_cycle(t0 + 7);
        di = 16'h0002;
        to_cycle(t0 + 8);
        cont = 1'b0;
        chk("t4_sel_restart", sel, 0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (!busy) cnt++;
            step();
        end
        chk("t4_no_idle", cnt, 0);
        wait_idle("t4_idle", 50);

        // 5: abort mid-settle keeps the partial word; start+abort stays idle
        di = 16'hA5C3;
        issue(16'hFFFF, t0);
        to_cycle(t0 + 22);
        chk("t5_sel7", sel, 7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_sel", sel, 0);
        chk("t5_valid", wif.word_valid, 0);
        chk("t5_partial", wif.scan_word, 16'h0043);
        chan_mask = 16'hFFFF;
        start     = 1'b1;
        abort     = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_sa_busy", busy, 0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (wif.word_valid || busy) cnt++;
            step();
        end
        chk("t5_sa_quiet", cnt, 0);

        // 6: async reset mid-SAMPLE, then a clean full scan
        issue(16'hFFFF, t0);
        to_cycle(t0 + 9);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_sel", sel, 0);
        chk("t6_busy", busy, 0);
        chk("t6_valid", wif.word_valid, 0);
        chk("t6_word", wif.scan_word, 0);
        step();
        rst_n = 1'b1;
        step();
        di = 16'h3C5A;
        issue(16'hFFFF, t0);
        sb.push_back('{word: 16'h3C5A, rise: t0 + 49});
        wait_idle("t6_idle", 100);
        step();

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
